// File: rtl/bus_master_arbiter_pkg.sv
// Shared types for the two-master bus arbiter (instruction fetch / data access).
// Compile-time option BUS_ARBITER_ROUND_ROBIN_EN selects round-robin contention handling.
package bus_master_arbiter_pkg;

  typedef logic [31:0] Word_t;
  typedef logic [3:0]  ByteMask_t;

  typedef struct packed {
    logic base;
    logic rst;
  } Clock_t;

  typedef enum logic [1:0] {
    OWNER_NONE,
    OWNER_INST,
    OWNER_DATA
  } BusOwner_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BUSY_I,
    ARB_BUSY_D
  } ArbState_t;

  localparam ByteMask_t MASK_ALL   = 4'b1111;
  localparam logic      GRANT_INST = 1'b0;
  localparam logic      GRANT_DATA = 1'b1;

endpackage

// File: rtl/bus_master_arbiter_if.sv
// CPU-side masters and slave-side bus bundled together; the arbiter takes the slave view,
// the surrounding core/decoder environment takes the master view.
interface bus_master_arbiter_if;

  bus_master_arbiter_pkg::Word_t     if_address;
  logic                              if_read;
  logic                              if_stall;
  bus_master_arbiter_pkg::Word_t     if_data_rd;
  bus_master_arbiter_pkg::Word_t     if_data_rd_2;

  bus_master_arbiter_pkg::Word_t     mem_address;
  logic                              mem_read;
  logic                              mem_write;
  bus_master_arbiter_pkg::Word_t     mem_data_wr;
  bus_master_arbiter_pkg::ByteMask_t mem_mask;
  logic                              mem_stall;
  bus_master_arbiter_pkg::Word_t     mem_data_rd;

  bus_master_arbiter_pkg::Word_t     bus_address;
  logic                              bus_read;
  logic                              bus_write;
  bus_master_arbiter_pkg::Word_t     bus_data_wr;
  bus_master_arbiter_pkg::ByteMask_t bus_mask;
  logic                              bus_stall;
  bus_master_arbiter_pkg::Word_t     bus_data_rd;
  bus_master_arbiter_pkg::Word_t     bus_data_rd_2;

  modport slave (
    input  if_address, if_read,
    output if_stall, if_data_rd, if_data_rd_2,
    input  mem_address, mem_read, mem_write, mem_data_wr, mem_mask,
    output mem_stall, mem_data_rd,
    output bus_address, bus_read, bus_write, bus_data_wr, bus_mask,
    input  bus_stall, bus_data_rd, bus_data_rd_2
  );

  modport master (
    output if_address, if_read,
    input  if_stall, if_data_rd, if_data_rd_2,
    output mem_address, mem_read, mem_write, mem_data_wr, mem_mask,
    input  mem_stall, mem_data_rd,
    input  bus_address, bus_read, bus_write, bus_data_wr, bus_mask,
    output bus_stall, bus_data_rd, bus_data_rd_2
  );

endinterface

// File: rtl/bus_master_arbiter_pick.sv
// Combinational winner selection between the instruction and data masters.
// With BUS_ARBITER_ROUND_ROBIN_EN defined, contention goes to the master that did not win last.
module bus_arb_pick
  import bus_master_arbiter_pkg::*;
#(
  parameter bit DATA_PRIORITY = 1'b1
) (
  input  logic      req_i,
  input  logic      req_d,
  input  logic      last_grant,
  output BusOwner_t owner
);

`ifndef BUS_ARBITER_ROUND_ROBIN_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

  always_comb begin
    owner = OWNER_NONE;
    if (req_i && req_d) begin
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
      owner = (last_grant == GRANT_INST) ? OWNER_DATA : OWNER_INST;
`else
      owner = DATA_PRIORITY ? OWNER_DATA : OWNER_INST;
`endif
    end else if (req_d) begin
      owner = OWNER_DATA;
    end else if (req_i) begin
      owner = OWNER_INST;
    end
  end

endmodule

// File: rtl/bus_master_arbiter.sv
// Two-master bus arbiter: zero-latency forwarding, grant locked while the slave stalls.
// Optional macro BUS_ARBITER_ROUND_ROBIN_EN switches contention from fixed priority to round robin.
//
// state      | meaning
// ARB_IDLE   | no locked owner; winner picked combinationally each cycle
// ARB_BUSY_I | instruction master holds the bus until the slave drops stall
// ARB_BUSY_D | data master holds the bus until the slave drops stall
module bus_master_arbiter
  import bus_master_arbiter_pkg::*;
#(
  parameter bit DATA_PRIORITY = 1'b1
) (
  input Clock_t                clk,
  bus_master_arbiter_if.slave  bus_if
);

  ArbState_t state_q, state_d;
  logic      last_grant_q, last_grant_d;
  logic      req_i, req_d;
  BusOwner_t pick_owner, owner;

  Word_t     bus_address_o, bus_data_wr_o, if_data_rd_o, if_data_rd_2_o, mem_data_rd_o;
  ByteMask_t bus_mask_o;
  logic      bus_read_o, bus_write_o, if_stall_o, mem_stall_o;

  assign req_i = bus_if.if_read;
  assign req_d = bus_if.mem_read | bus_if.mem_write;

  bus_arb_pick #(.DATA_PRIORITY(DATA_PRIORITY)) u_pick (
    .req_i      (req_i),
    .req_d      (req_d),
    .last_grant (last_grant_q),
    .owner      (pick_owner)
  );

  always_ff @(posedge clk.base) begin
    if (!clk.rst) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= GRANT_INST;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // A locked owner that drops its request is an abort: the bus goes quiet for that cycle.
  always_comb begin
    owner = OWNER_NONE;
    case (state_q)
      ARB_IDLE:   owner = pick_owner;
      ARB_BUSY_I: if (req_i) owner = OWNER_INST;
      ARB_BUSY_D: if (req_d) owner = OWNER_DATA;
      default:    owner = OWNER_NONE;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      ARB_IDLE: begin
        if (owner != OWNER_NONE) begin
          last_grant_d = (owner == OWNER_DATA) ? GRANT_DATA : GRANT_INST;
        end
        if (bus_if.bus_stall && owner == OWNER_INST) begin
          state_d = ARB_BUSY_I;
        end else if (bus_if.bus_stall && owner == OWNER_DATA) begin
          state_d = ARB_BUSY_D;
        end
      end
      ARB_BUSY_I, ARB_BUSY_D: begin
        if (owner == OWNER_NONE || !bus_if.bus_stall) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    bus_address_o  = '0;
    bus_read_o     = 1'b0;
    bus_write_o    = 1'b0;
    bus_data_wr_o  = '0;
    bus_mask_o     = '0;
    if_stall_o     = 1'b0;
    if_data_rd_o   = '0;
    if_data_rd_2_o = '0;
    mem_stall_o    = 1'b0;
    mem_data_rd_o  = '0;
    if (!clk.rst) begin
      if_stall_o  = 1'b1;
      mem_stall_o = 1'b1;
    end else begin
      case (owner)
        OWNER_INST: begin
          bus_address_o  = bus_if.if_address;
          bus_read_o     = bus_if.if_read;
          bus_mask_o     = MASK_ALL;
          if_stall_o     = bus_if.bus_stall;
          if_data_rd_o   = bus_if.bus_data_rd;
          if_data_rd_2_o = bus_if.bus_data_rd_2;
        end
        OWNER_DATA: begin
          bus_address_o = bus_if.mem_address;
          bus_read_o    = bus_if.mem_read;
          bus_write_o   = bus_if.mem_write;
          bus_data_wr_o = bus_if.mem_data_wr;
          bus_mask_o    = bus_if.mem_mask;
          mem_stall_o   = bus_if.bus_stall;
          mem_data_rd_o = bus_if.bus_data_rd;
        end
        default: ;
      endcase
      if (req_i && owner != OWNER_INST) if_stall_o = 1'b1;
      if (req_d && owner != OWNER_DATA) mem_stall_o = 1'b1;
    end
  end

  assign bus_if.bus_address  = bus_address_o;
  assign bus_if.bus_read     = bus_read_o;
  assign bus_if.bus_write    = bus_write_o;
  assign bus_if.bus_data_wr  = bus_data_wr_o;
  assign bus_if.bus_mask     = bus_mask_o;
  assign bus_if.if_stall     = if_stall_o;
  assign bus_if.if_data_rd   = if_data_rd_o;
  assign bus_if.if_data_rd_2 = if_data_rd_2_o;
  assign bus_if.mem_stall    = mem_stall_o;
  assign bus_if.mem_data_rd  = mem_data_rd_o;

endmodule
